// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from incoming
// hsync/vsync/de, measures line and frame totals, and reports timing lock.
module vga_timing_decoder #(
    parameter int HW          = 11,
    parameter int VW          = 10,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic          pixel_valid,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [HW-1:0] h_total,
    output logic [VW-1:0] v_total,
    output logic          locked
);
    // state    | meaning
    // UNLOCKED | counting consecutive frames with identical h/v totals
    // LOCKED   | timing stable; any mismatch or sync timeout drops lock
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    localparam logic          HS_ACT   = (HS_POL != 0);
    localparam logic          VS_ACT   = (VS_POL != 0);
    localparam logic [HW-1:0] HMAX     = {HW{1'b1}};
    localparam logic [HW-1:0] HMAX_M1  = HMAX - HW'(1);
    localparam logic [VW-1:0] VMAX     = {VW{1'b1}};
    localparam logic [VW-1:0] VMAX_M1  = VMAX - VW'(1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_FRAMES);

    logic          s1_hsync, s2_hsync, s1_vsync, s2_vsync, s1_de, s2_de;
    logic [1:0]    prime;
    logic [HW-1:0] hcnt, prev_h, h_meas, h_new;
    logic [VW-1:0] vcnt, prev_v;
    logic          prev_valid;
    logic          h_edge, v_edge, de_rise, de_fall, h_to, v_to, same_timing;
    lock_state_t   state, state_nxt;
    logic [3:0]    match_cnt, match_nxt;

    // Edges are ignored until s2 holds a real pin sample, so a sync held
    // active through reset does not produce a pulse on release.
    assign h_edge  = prime[1] && (s1_hsync == HS_ACT) && (s2_hsync != HS_ACT);
    assign v_edge  = prime[1] && (s1_vsync == VS_ACT) && (s2_vsync != VS_ACT);
    assign de_rise = s1_de && !s2_de;
    assign de_fall = !s1_de && s2_de;

    assign h_meas      = (hcnt == HMAX) ? HMAX : hcnt + HW'(1);
    assign h_new       = h_edge ? h_meas : h_total;
    assign h_to        = (hcnt == HMAX_M1) && !h_edge;
    assign v_to        = h_edge && !v_edge && (vcnt == VMAX_M1);
    assign same_timing = prev_valid && (h_new == prev_h) && (vcnt == prev_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hsync    <= ~HS_ACT;
            s2_hsync    <= ~HS_ACT;
            s1_vsync    <= ~VS_ACT;
            s2_vsync    <= ~VS_ACT;
            s1_de       <= 1'b0;
            s2_de       <= 1'b0;
            prime       <= 2'b00;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            h_total     <= '0;
            v_total     <= '0;
            pixel_valid <= 1'b0;
            x           <= '0;
            y           <= '0;
            prev_h      <= '0;
            prev_v      <= '0;
            prev_valid  <= 1'b0;
        end else begin
            s1_hsync    <= hsync;
            s2_hsync    <= s1_hsync;
            s1_vsync    <= vsync;
            s2_vsync    <= s1_vsync;
            s1_de       <= de;
            s2_de       <= s1_de;
            prime       <= {prime[0], 1'b1};
            line_start  <= h_edge;
            frame_start <= v_edge;

            if (h_edge)
                hcnt <= '0;
            else if (hcnt != HMAX)
                hcnt <= hcnt + HW'(1);

            if (h_to)
                h_total <= HMAX;
            else if (h_edge)
                h_total <= h_meas;

            // A line starting together with vsync is already line 0 of the frame.
            if (v_edge)
                vcnt <= h_edge ? VW'(1) : '0;
            else if (h_edge && vcnt != VMAX)
                vcnt <= vcnt + VW'(1);

            if (v_edge) begin
                v_total    <= vcnt;
                prev_h     <= h_new;
                prev_v     <= vcnt;
                prev_valid <= 1'b1;
            end

            pixel_valid <= s1_de;
            if (de_rise)
                x <= '0;
            else if (s1_de)
                x <= x + HW'(1);

            if (v_edge)
                y <= '0;
            else if (de_fall)
                y <= y + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNLOCKED;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        if (h_to || v_to) begin
            state_nxt = UNLOCKED;
            match_nxt = '0;
        end else if (v_edge) begin
            case (state)
                UNLOCKED: begin
                    if (same_timing) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 >= LOCK_TGT)
                            state_nxt = LOCKED;
                    end else begin
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!same_timing) begin
                        state_nxt = UNLOCKED;
                        match_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                    match_nxt = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down video timing
// (100 clocks/line, 20 lines/frame) so many frames fit in a short run.
module tb_vga_timing_decoder;
    localparam int LEN = 100;
    localparam int HSW = 10;
    localparam int HST = 20;
    localparam int FPW = 8;
    localparam int NL  = 20;
    localparam int VSW = 2;
    localparam int VST = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, de;
    logic        hsync_n, vsync_n, de_n;

    logic        pixel_valid, line_start, frame_start, locked;
    logic [10:0] x, h_total;
    logic [9:0]  y, v_total;
    logic        n_pixel_valid, n_line_start, n_frame_start, n_locked;
    logic [10:0] n_x, n_h_total;
    logic [9:0]  n_y, n_v_total;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise = 0;
    logic hs_prev = 1'b0;
    logic neg_hold_low = 1'b0;

    logic fs_pulse, fs_ls, fs_lock, fs_pulse2, fs_ls2, n_fs_lock;
    int   fs_ht, fs_vt;
    logic pre_pv, fp_pv, lp_pv;
    int   fp_x, fp_y, lp_x, lp_y;

    always #5 clk = ~clk;

    vga_timing_decoder #(.HW(11), .VW(10), .HS_POL(1), .VS_POL(1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
        .pixel_valid(pixel_valid), .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .locked(locked)
    );

    vga_timing_decoder #(.HW(11), .VW(10), .HS_POL(0), .VS_POL(0), .LOCK_FRAMES(2)) dut_n (
        .clk(clk), .reset(reset), .hsync(hsync_n), .vsync(vsync_n), .de(de_n),
        .pixel_valid(n_pixel_valid), .x(n_x), .y(n_y), .line_start(n_line_start),
        .frame_start(n_frame_start), .h_total(n_h_total), .v_total(n_v_total), .locked(n_locked)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clock of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic hs, input logic vs, input logic d);
        if (hs && !hs_prev)
            last_rise = cyc;
        hs_prev = hs;
        hsync   = hs;
        vsync   = vs;
        de      = d;
        hsync_n = neg_hold_low ? 1'b0 : ~hs;
        vsync_n = ~vs;
        de_n    = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_line(input int len, input int ln);
        for (int c = 0; c < len; c++) begin
            step(c < HSW, ln < VSW, (ln >= VST) && (ln < NL-1) && (c >= HST) && (c < len-FPW));
            if (ln == 0 && c == 1) begin
                fs_pulse  = frame_start;
                fs_ls     = line_start;
                fs_lock   = locked;
                fs_ht     = int'(h_total);
                fs_vt     = int'(v_total);
                n_fs_lock = n_locked;
            end
            if (ln == 0 && c == 2) begin
                fs_pulse2 = frame_start;
                fs_ls2    = line_start;
            end
            if (ln == VST && c == HST)
                pre_pv = pixel_valid;
            if (ln == VST && c == HST+1) begin
                fp_pv = pixel_valid;
                fp_x  = int'(x);
                fp_y  = int'(y);
            end
            if (ln == NL-2 && c == len-FPW) begin
                lp_pv = pixel_valid;
                lp_x  = int'(x);
                lp_y  = int'(y);
            end
        end
    endtask

    task automatic run_frame(input int len);
        for (int ln = 0; ln < NL; ln++)
            drive_line(len, ln);
    endtask

    initial begin
        reset = 1'b1;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        hsync_n = 1'b1; vsync_n = 1'b1; de_n = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle_line_start", int'(line_start), 0);
            check("idle_frame_start", int'(frame_start), 0);
            check("idle_n_line_start", int'(n_line_start), 0);
        end
        check("idle_x", int'(x), 0);
        check("idle_y", int'(y), 0);
        check("idle_pixel_valid", int'(pixel_valid), 0);
        check("idle_h_total", int'(h_total), 0);
        check("idle_v_total", int'(v_total), 0);
        check("idle_locked", int'(locked), 0);

        run_frame(LEN);
        check("f1_frame_start", int'(fs_pulse), 1);
        check("f1_line_start", int'(fs_ls), 1);
        check("f1_locked", int'(fs_lock), 0);

        run_frame(LEN);
        check("f2_h_total", fs_ht, 100);
        check("f2_v_total", fs_vt, 20);
        check("f2_locked", int'(fs_lock), 0);
        check("f2_frame_start_width", int'(fs_pulse2), 0);
        check("f2_line_start_width", int'(fs_ls2), 0);

        run_frame(LEN);
        check("f3_locked", int'(fs_lock), 0);
        check("f3_h_total", fs_ht, 100);

        run_frame(LEN);
        check("f4_locked", int'(fs_lock), 1);
        check("f4_neg_locked", int'(n_fs_lock), 1);
        check("f4_pre_pixel_valid", int'(pre_pv), 0);
        check("f4_first_pixel_valid", int'(fp_pv), 1);
        check("f4_first_x", fp_x, 0);
        check("f4_first_y", fp_y, 0);
        check("f4_last_pixel_valid", int'(lp_pv), 1);
        check("f4_last_x", lp_x, 71);
        check("f4_last_y", lp_y, 13);

        run_frame(90);
        check("f5_locked", int'(fs_lock), 1);
        run_frame(LEN);
        check("f6_h_total", fs_ht, 90);
        check("f6_v_total", fs_vt, 20);
        check("f6_locked", int'(fs_lock), 0);
        run_frame(LEN);
        check("f7_locked", int'(fs_lock), 0);
        check("f7_h_total", fs_ht, 100);
        run_frame(LEN);
        check("f8_locked", int'(fs_lock), 0);
        run_frame(LEN);
        check("f9_relocked", int'(fs_lock), 1);

        while (cyc < last_rise + 2048)
            step(1'b0, 1'b0, 1'b0);
        check("hto_before_locked", int'(locked), 1);
        check("hto_before_h_total", int'(h_total), 100);
        step(1'b0, 1'b0, 1'b0);
        check("hto_locked", int'(locked), 0);
        check("hto_h_total", int'(h_total), 2047);

        for (int f = 0; f < 3; f++)
            run_frame(LEN);
        check("f12_locked", int'(fs_lock), 0);
        run_frame(LEN);
        check("f13_locked", int'(fs_lock), 1);

        for (int ln = 0; ln < 10; ln++)
            drive_line(LEN, ln);
        for (int c = 0; c < 50; c++)
            step(c < HSW, 1'b0, c >= HST);
        check("pre_reset_locked", int'(locked), 1);

        reset = 1'b1;
        neg_hold_low = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        check("rst_pixel_valid", int'(pixel_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_line_start", int'(line_start), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_h_total", int'(h_total), 0);
        check("rst_v_total", int'(v_total), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_n_pixel_valid", int'(n_pixel_valid), 0);
        check("rst_n_x", int'(n_x), 0);
        check("rst_n_y", int'(n_y), 0);
        check("rst_n_line_start", int'(n_line_start), 0);
        check("rst_n_frame_start", int'(n_frame_start), 0);
        check("rst_n_h_total", int'(n_h_total), 0);
        check("rst_n_v_total", int'(n_v_total), 0);
        check("rst_n_locked", int'(n_locked), 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("post_rst_n_line_start", int'(n_line_start), 0);
            check("post_rst_line_start", int'(line_start), 0);
            check("post_rst_locked", int'(locked), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
